// File: rtl/uart_matrix_pkg.sv
// uart_matrix_pkg: shared receiver constants and state encoding for the UART crossbar
package uart_matrix_pkg;
  localparam int DATA_BITS = 8;
  localparam int CNT_W = $clog2(DATA_BITS);
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
endpackage

// File: rtl/uart_rx_1x.sv
// uart_rx_1x: one-sample-per-bit 8N1 receiver with a one-cycle byte-valid strobe
module uart_rx_1x
  import uart_matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_byte,
  output logic                 o_valid
);
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_sh;
  // frame FSM: start bit, LSB-first data shift, stop check, wait-for-idle after framing error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        RX_IDLE: if (!i_rx) begin
          r_state <= RX_DATA;
          r_cnt   <= '0;
        end
        RX_DATA: begin
          r_sh  <= {i_rx, r_sh[DATA_BITS-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_BITS-1)) r_state <= RX_STOP;
        end
        RX_STOP: begin
          o_valid <= i_rx;
          r_state <= i_rx ? RX_IDLE : RX_WAIT;
        end
        default: if (i_rx) r_state <= RX_IDLE;
      endcase
    end
  // the shift register is untouched until the next frame's first data bit, so it is stable while o_valid is high
  assign o_byte = r_sh;
endmodule

// File: rtl/uart_matrix.sv
// uart_matrix: RX_N-channel UART receive crossbar dispatching bytes onto one bus with LUT-routed strobe masks
module uart_matrix
  import uart_matrix_pkg::*;
#(
  parameter int RX_N = 2,
  parameter int TX_N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RX_N-1:0]      rx,
  input  logic [TX_N-1:0]      lut_data,
  input  logic [RX_N-1:0]      lut_addr,
  input  logic                 lut_cke,
  output logic [DATA_BITS-1:0] tx,
  output logic [TX_N-1:0]      tx_cke
);
  logic [DATA_BITS-1:0] w_rx_byte [RX_N];
  logic [RX_N-1:0]      w_valid;
  logic [DATA_BITS-1:0] w_byte [RX_N];
  logic [RX_N-1:0]      w_pend;
  logic [RX_N-1:0]      w_gnt;
  logic                 w_any;
  logic [DATA_BITS-1:0] w_sel_byte;
  logic [TX_N-1:0]      w_sel_mask;
  logic [TX_N-1:0]      r_lut [RX_N];
  logic [DATA_BITS-1:0] r_hold [RX_N];
  logic [RX_N-1:0]      r_pend;

  for (genvar g = 0; g < RX_N; g++) begin : g_rx
    uart_rx_1x u_rx (
      .clk     (clk),
      .rst     (rst),
      .i_rx    (rx[g]),
      .o_byte  (w_rx_byte[g]),
      .o_valid (w_valid[g])
    );
  end

  // a freshly received byte competes in its valid cycle, so an uncontested byte leaves on the very next edge
  always_comb begin
    w_pend = r_pend | w_valid;
    for (int k = 0; k < RX_N; k++) w_byte[k] = w_valid[k] ? w_rx_byte[k] : r_hold[k];
  end

  // fixed-priority arbiter: lowest pending channel wins, its byte and current LUT mask are selected
  always_comb begin
    w_gnt      = '0;
    w_any      = 1'b0;
    w_sel_byte = '0;
    w_sel_mask = '0;
    for (int k = 0; k < RX_N; k++)
      if (w_pend[k] && !w_any) begin
        w_any      = 1'b1;
        w_gnt[k]   = 1'b1;
        w_sel_byte = w_byte[k];
        w_sel_mask = r_lut[k];
      end
  end

  // LUT writes, holding registers, pending flags and registered dispatch outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < RX_N; k++) begin
        r_lut[k]  <= '0;
        r_hold[k] <= '0;
      end
      r_pend <= '0;
      tx     <= '0;
      tx_cke <= '0;
    end else begin
      for (int k = 0; k < RX_N; k++) begin
        if (lut_cke && lut_addr == RX_N'(k)) r_lut[k] <= lut_data;
        if (w_valid[k]) r_hold[k] <= w_rx_byte[k];
      end
      r_pend <= w_pend & ~w_gnt;
      tx_cke <= w_any ? w_sel_mask : '0;
      tx     <= (w_any && |w_sel_mask) ? w_sel_byte : tx;
    end
endmodule

// File: tb/tb_uart_matrix.sv
// tb_uart_matrix: directed self-checking bench for the UART receive crossbar
module tb_uart_matrix;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rx = 2'b11;
  logic [2:0] lut_data = '0;
  logic [1:0] lut_addr = '0;
  logic       lut_cke = 1'b0;
  logic [7:0] tx;
  logic [2:0] tx_cke;
  int errors = 0;
  int checks = 0;

  uart_matrix #(.RX_N(2), .TX_N(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .lut_data (lut_data),
    .lut_addr (lut_addr),
    .lut_cke  (lut_cke),
    .tx       (tx),
    .tx_cke   (tx_cke)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lut_wr(input logic [1:0] a, input logic [2:0] d);
    lut_addr = a;
    lut_data = d;
    lut_cke  = 1'b1;
    tick();
    lut_cke  = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, input logic a0, input logic s0,
                       input logic [7:0] b1, input logic a1, input logic s1);
    logic [9:0] f0, f1;
    f0 = {s0, b0, 1'b0};
    f1 = {s1, b1, 1'b0};
    for (int j = 0; j < 10; j++) begin
      rx[0] = a0 ? f0[j] : 1'b1;
      rx[1] = a1 ? f1[j] : 1'b1;
      tick();
      chk("frame_cke", tx_cke, 0);
    end
    rx = 2'b11;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] b, input logic [2:0] m);
    tick();
    chk({tag, "_tx"}, tx, b);
    chk({tag, "_cke"}, tx_cke, m);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_tx", tx, 0);
    chk("rst_cke", tx_cke, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) expect_out("idle", 8'h00, 3'b000);
    lut_addr = 2'd0;
    lut_data = 3'b101;
    lut_cke  = 1'b1;
    tick();
    tick();
    tick();
    lut_cke = 1'b0;
    frame(8'h33, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    expect_out("single", 8'h33, 3'b101);
    expect_out("single_after", 8'h33, 3'b000);
    frame(8'h33, 1'b1, 1'b1, 8'hCC, 1'b1, 1'b1);
    expect_out("both_ch0", 8'h33, 3'b101);
    expect_out("mask0_ch1", 8'h33, 3'b000);
    expect_out("mask0_after", 8'h33, 3'b000);
    lut_wr(2'd1, 3'b011);
    frame(8'hAA, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    expect_out("arb_k", 8'hAA, 3'b101);
    expect_out("arb_k1", 8'h55, 3'b011);
    expect_out("arb_k2", 8'h55, 3'b000);
    frame(8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    rx[0] = 1'b0;
    for (int i = 0; i < 3; i++) expect_out("ferr_wait", 8'h55, 3'b000);
    rx[0] = 1'b1;
    for (int i = 0; i < 2; i++) expect_out("ferr_idle", 8'h55, 3'b000);
    frame(8'h3C, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    expect_out("ferr_recover", 8'h3C, 3'b101);
    frame(8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    lut_addr = 2'd0;
    lut_data = 3'b010;
    lut_cke  = 1'b1;
    expect_out("wr_same_cycle", 8'h5A, 3'b101);
    lut_cke = 1'b0;
    expect_out("wr_after", 8'h5A, 3'b000);
    frame(8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    expect_out("wr_new_mask", 8'hA5, 3'b010);
    lut_wr(2'd2, 3'b111);
    lut_wr(2'd3, 3'b111);
    frame(8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    expect_out("addr_oob", 8'h0F, 3'b010);
    begin
      logic [9:0] f;
      f = {1'b1, 8'hF0, 1'b0};
      for (int j = 0; j < 5; j++) begin
        rx[0] = f[j];
        tick();
      end
    end
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 0);
    chk("async_rst_cke", tx_cke, 0);
    rx = 2'b11;
    tick();
    tick();
    rst = 1'b0;
    lut_wr(2'd0, 3'b111);
    for (int i = 0; i < 12; i++) expect_out("post_rst", 8'h00, 3'b000);
    frame(8'h81, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    expect_out("post_rst_frame", 8'h81, 3'b111);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
